decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32I decode stage between fetch and execute. Accepts {pc, iword} under a
//  valid/ready handshake, produces all fields, a full sign-extended immediate, an instr
//  format tag and an illegal flag. A 2-entry skid buffer gives full throughput under
//  backpressure. Flush support and a saturating illegal-instruction counter are included.
// PARAMETERS
//  XLEN      32  datapath / immediate width (32 or 64); shamt width = $clog2(XLEN)
//  PC_W      32  program counter width
//  CNT_W     16  width of illegal-instruction counter (saturates)
// PORTS
//  clk         in   1      clock
//  rst         in   1      synchronous, active-high reset
//  flush       in   1      discard all buffered instructions this cycle
//  in_valid    in   1      fetch offers pc/iword
//  in_ready    out  1      stage can accept (registered)
//  in_pc       in   PC_W   pc of offered instruction
//  in_iword    in   32     instruction word
//  out_valid   out  1      decoded instruction available
//  out_ready   in   1      execute consumes
//  out_pc      out  PC_W   pc, passed through
//  out_opcode  out  7      iword[6:0]
//  out_rd      out  5      iword[11:7]
//  out_rs1     out  5      iword[19:15]
//  out_rs2     out  5      iword[24:20]
//  out_funct3  out  3      iword[14:12]
//  out_funct7  out  7      iword[31:25]
//  out_imm     out  XLEN   sign-extended immediate per format; 0 for R-type
//  out_fmt     out  3      FMT_R/I/S/B/U/J/NONE
//  out_illegal out  1      instruction not legal RV32I (subset below)
//  illegal_cnt out  CNT_W  count of illegal instrs delivered (out_valid&&out_ready)
// BEHAVIOUR
//  - Reset: out_valid=0, in_ready=1, illegal_cnt=0, all out_* data=0, buffer empty.
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Latency 1: word accepted at edge N (in_valid&&in_ready) visible on out_* after N.
//  - Buffer: main reg + skid reg. in_ready = !skid_full. Accept when out stalled and main
//    full -> goes to skid; in_ready drops next cycle. On drain, skid moves to main. Order
//    strictly preserved; no bubble when out_ready held 1 (1 instr/cycle).
//  - out_* stable while out_valid && !out_ready.
//  - flush: both entries invalid next cycle, out_valid=0, in_ready=1; flush beats a
//    simultaneous accept (word dropped). Counter not cleared by flush.
//  - Imm: I sext(iw[31:20]); shifts-imm zext(iw[20+:log2 XLEN]); S sext({iw[31:25],iw[11:7]});
//    B sext({iw[31],iw[7],iw[30:25],iw[11:8],0}); U sext({iw[31:12],12'b0});
//    J sext({iw[31],iw[19:12],iw[20],iw[30:21],0}).
//  - Formats: LUI/AUIPC U; JAL J; JALR/LOAD/OP-IMM I; STORE S; BRANCH B; OP R; FENCE/SYSTEM I.
//  - Illegal if: iw[1:0]!=2'b11; unknown opcode; JALR f3!=0; BRANCH f3 in {010,011};
//    LOAD f3 in {011,110,111}; STORE f3>010; OP f7 not 0x00/0x20, or 0x20 with f3 not
//    000/101; SLLI f7!=0; SRLI/SRAI f7 not 0x00/0x20. Illegal words still flow through
//    with out_fmt=FMT_NONE, out_imm=0.
//  - illegal_cnt increments on handshake of an illegal instr; saturates at all-ones.
//  - Decode is computed combinationally from iword before the main/skid registers.
// STRUCTURE
//  - Package rv_pkg: opcode localparams (OPC_LUI..OPC_SYSTEM), funct3/funct7 constants,
//    FMT_* encodings.
//  - Sub-module rv_imm_gen (combinational: iword, fmt -> imm); skid logic stays inline.
// TESTING
//  - 0xFFF00093 (ADDI x1,x0,-1) -> rd=1, fmt=I, imm=0xFFFFFFFF, illegal=0, 1-cycle latency.
//  - 0x0020A423 (SW x2,8(x1)) -> fmt=S, rs1=1, rs2=2, imm=0x8; 0xFE000EE3 (BEQ -4) -> imm=0xFFFFFFFC.
//  - 0x001000EF (JAL x1,+2048) -> fmt=J, imm=0x800; 0x123452B7 (LUI) -> imm=0x12345000.
//  - 0x00000000 and 0x4000F0B3 (f7=0x20,f3=111) -> illegal=1, illegal_cnt 0->1->2.
//  - out_ready=0, stream 3 words -> 2 accepted, in_ready=0; release -> 3 out in order, no bubbles.
//  - flush with 2 buffered + in_valid=1 -> next cycle out_valid=0, in_ready=1, none emitted.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_pkg
// Purpose  : Shared RV32I decode constants for the decode stage. Holds the
//            major opcodes, the funct3/funct7 values that legality depends on,
//            the instruction-format tag encoding and the per-entry struct that
//            the main and skid registers carry.
// Revision : 1.0 - initial release
// ============================================================================
package rv_pkg;

    // Major opcodes (iword[6:0]); all of them end in 2'b11
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct3 values that legality depends on
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_SW      = 3'b010;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // Instruction format tag
    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    // Decoded fields that do not depend on module parameters
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        fmt_e       fmt;
        logic       illegal;
    } dec_fields_t;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/rv_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : rv_imm_gen
// Purpose  : Combinational immediate generator. Builds the sign-extended
//            XLEN-bit immediate for the given instruction format. Shift-
//            immediate instructions take a zero-extended shamt instead.
//            R-type and FMT_NONE produce zero.
// Ports    : iword     in  [31:7]  instruction word (opcode bits not needed)
//            fmt       in  fmt_e   format tag from the decoder
//            shift_imm in  1       I-type word is SLLI/SRLI/SRAI
//            imm       out XLEN    immediate
// Revision : 1.0 - initial release
// ============================================================================
module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     iword,
    input  fmt_e            fmt,
    input  logic            shift_imm,
    output logic [XLEN-1:0] imm
);

    localparam int SHAMT_W = $clog2(XLEN);

    // Sign extension is done by a size cast of a signed operand
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: begin
                if (shift_imm) begin
                    imm = XLEN'(iword[20 +: SHAMT_W]);
                end else begin
                    imm = XLEN'($signed(iword[31:20]));
                end
            end
            FMT_S: imm = XLEN'($signed({iword[31:25], iword[11:7]}));
            FMT_B: imm = XLEN'($signed({iword[31], iword[7], iword[30:25],
                                        iword[11:8], 1'b0}));
            FMT_U: imm = XLEN'($signed({iword[31:12], 12'b0}));
            FMT_J: imm = XLEN'($signed({iword[31], iword[19:12], iword[20],
                                        iword[30:21], 1'b0}));
            default: imm = '0;
        endcase
    end

endmodule : rv_imm_gen
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Purpose  : Registered RV32I decode stage between fetch and execute. Decodes
//            {pc, iword} combinationally and captures the result in a main
//            register backed by a skid register, giving one instruction per
//            cycle under backpressure with order preserved. Supports flush and
//            keeps a saturating count of delivered illegal instructions.
// Ports    : clk, rst            clock, synchronous active-high reset
//            flush               drop both buffered entries
//            in_valid/in_ready   fetch handshake (in_ready registered)
//            in_pc, in_iword     offered instruction
//            out_valid/out_ready execute handshake
//            out_pc .. out_funct7  pass-through pc and raw fields
//            out_imm, out_fmt    immediate and format tag
//            out_illegal         word is not legal RV32I
//            illegal_cnt         saturating count of delivered illegal words
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [31:0]      in_iword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // ------------------------------------------------------------------
    // Combinational decode of the offered word
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    fmt_e        w_fmt;
    logic        w_illegal;
    logic        w_shift_imm;
    logic [XLEN-1:0] w_imm;
    dec_fields_t w_dec;

    assign w_opcode = in_iword[6:0];
    assign w_funct3 = in_iword[14:12];
    assign w_funct7 = in_iword[31:25];

    // Every known opcode ends in 2'b11, so a word with iword[1:0] != 2'b11
    // falls into the default arm and is flagged there.
    always_comb begin
        w_fmt       = FMT_NONE;
        w_illegal   = 1'b0;
        w_shift_imm = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: w_fmt = FMT_U;
            OPC_JAL:            w_fmt = FMT_J;
            OPC_JALR: begin
                w_fmt     = FMT_I;
                w_illegal = (w_funct3 != F3_JALR);
            end
            OPC_BRANCH: begin
                w_fmt     = FMT_B;
                w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            OPC_LOAD: begin
                w_fmt     = FMT_I;
                w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                            (w_funct3 == 3'b111);
            end
            OPC_STORE: begin
                w_fmt     = FMT_S;
                w_illegal = (w_funct3 > F3_SW);
            end
            OPC_OP_IMM: begin
                w_fmt = FMT_I;
                case (w_funct3)
                    F3_SLL: begin
                        w_shift_imm = 1'b1;
                        w_illegal   = (w_funct7 != F7_BASE);
                    end
                    F3_SRL_SRA: begin
                        w_shift_imm = 1'b1;
                        w_illegal   = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
                    end
                    default: w_illegal = 1'b0;
                endcase
            end
            OPC_OP: begin
                w_fmt     = FMT_R;
                w_illegal = !((w_funct7 == F7_BASE) ||
                              ((w_funct7 == F7_ALT) &&
                               ((w_funct3 == F3_ADD_SUB) || (w_funct3 == F3_SRL_SRA))));
            end
            OPC_FENCE, OPC_SYSTEM: w_fmt = FMT_I;
            default: w_illegal = 1'b1;
        endcase
        // Illegal words carry no format, which also forces a zero immediate
        if (w_illegal) begin
            w_fmt = FMT_NONE;
        end
    end

    rv_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .iword     (in_iword[31:7]),
        .fmt       (w_fmt),
        .shift_imm (w_shift_imm),
        .imm       (w_imm)
    );

    assign w_dec = '{opcode:  w_opcode,
                     rd:      in_iword[11:7],
                     rs1:     in_iword[19:15],
                     rs2:     in_iword[24:20],
                     funct3:  w_funct3,
                     funct7:  w_funct7,
                     fmt:     w_fmt,
                     illegal: w_illegal};

    // ------------------------------------------------------------------
    // Main + skid buffer
    // ------------------------------------------------------------------
    logic              r_main_valid, r_skid_valid, r_in_ready;
    dec_fields_t       r_main_dec,   r_skid_dec;
    logic [PC_W-1:0]   r_main_pc,    r_skid_pc;
    logic [XLEN-1:0]   r_main_imm,   r_skid_imm;
    logic [CNT_W-1:0]  r_illegal_cnt;

    logic              w_main_valid_nxt, w_skid_valid_nxt;
    dec_fields_t       w_main_dec_nxt,   w_skid_dec_nxt;
    logic [PC_W-1:0]   w_main_pc_nxt,    w_skid_pc_nxt;
    logic [XLEN-1:0]   w_main_imm_nxt,   w_skid_imm_nxt;
    logic              w_accept, w_pop;

    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = r_main_valid && out_ready;

    // The skid can only be filled while main is full and stalled; in_ready
    // is low whenever the skid holds data, so a refill of main from the skid
    // never coincides with a new accept.
    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_dec_nxt   = r_main_dec;
        w_main_pc_nxt    = r_main_pc;
        w_main_imm_nxt   = r_main_imm;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_dec_nxt   = r_skid_dec;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_imm_nxt   = r_skid_imm;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid || w_pop) begin
            if (r_skid_valid) begin
                w_main_valid_nxt = 1'b1;
                w_main_dec_nxt   = r_skid_dec;
                w_main_pc_nxt    = r_skid_pc;
                w_main_imm_nxt   = r_skid_imm;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_dec_nxt   = w_dec;
                w_main_pc_nxt    = in_pc;
                w_main_imm_nxt   = w_imm;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_dec_nxt   = w_dec;
            w_skid_pc_nxt    = in_pc;
            w_skid_imm_nxt   = w_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid  <= 1'b0;
            r_main_dec    <= '0;
            r_main_pc     <= '0;
            r_main_imm    <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_dec    <= '0;
            r_skid_pc     <= '0;
            r_skid_imm    <= '0;
            r_in_ready    <= 1'b1;
            r_illegal_cnt <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_dec   <= w_main_dec_nxt;
            r_main_pc    <= w_main_pc_nxt;
            r_main_imm   <= w_main_imm_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_dec   <= w_skid_dec_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_skid_imm   <= w_skid_imm_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
            // A handshake during a flush still delivered the word
            if (w_pop && r_main_dec.illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = r_in_ready;
    assign out_valid   = r_main_valid;
    assign out_pc      = r_main_pc;
    assign out_opcode  = r_main_dec.opcode;
    assign out_rd      = r_main_dec.rd;
    assign out_rs1     = r_main_dec.rs1;
    assign out_rs2     = r_main_dec.rs2;
    assign out_funct3  = r_main_dec.funct3;
    assign out_funct7  = r_main_dec.funct7;
    assign out_imm     = r_main_imm;
    assign out_fmt     = r_main_dec.fmt;
    assign out_illegal = r_main_dec.illegal;
    assign illegal_cnt = r_illegal_cnt;

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Self-checking bench for decode_stage. Directed instruction and
//            buffering scenarios followed by randomized traffic, all compared
//            against a queue-based reference model of the stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] in_pc, in_iword, out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3, out_fmt;
    logic [15:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_iword(in_iword),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
        .out_funct7(out_funct7), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int   mcnt = 0;

    // Immediates computed as weighted bit sums; the sign bit carries a
    // negative weight.
    function automatic exp_t ref_decode(input logic [31:0] iw, input logic [31:0] pc);
        exp_t e;
        int   v = 0;
        bit   ok = 1'b1;
        logic [2:0] f = 3'd7;
        e.pc = pc; e.opcode = iw[6:0]; e.rd = iw[11:7]; e.rs1 = iw[19:15];
        e.rs2 = iw[24:20]; e.f3 = iw[14:12]; e.f7 = iw[31:25];
        case (iw[6:0])
            7'h37, 7'h17: begin f = 3'd4; v = int'(iw[31:12]) * 4096; end
            7'h6f: begin
                f = 3'd5;
                v = (iw[31] ? -(1 << 20) : 0) + int'(iw[19:12]) * 4096 +
                    int'(iw[20]) * 2048 + int'(iw[30:21]) * 2;
            end
            7'h63: begin
                f = 3'd3; ok = !(iw[14:12] inside {3'd2, 3'd3});
                v = (iw[31] ? -4096 : 0) + int'(iw[7]) * 2048 +
                    int'(iw[30:25]) * 32 + int'(iw[11:8]) * 2;
            end
            7'h23: begin
                f = 3'd2; ok = (iw[14:12] <= 3'd2);
                v = (iw[31] ? -2048 : 0) + int'(iw[30:25]) * 32 + int'(iw[11:7]);
            end
            7'h67, 7'h03, 7'h0f, 7'h73, 7'h13: begin
                f = 3'd1;
                v = (iw[31] ? -2048 : 0) + int'(iw[30:20]);
                if (iw[6:0] == 7'h67) ok = (iw[14:12] == 3'd0);
                if (iw[6:0] == 7'h03) ok = !(iw[14:12] inside {3'd3, 3'd6, 3'd7});
                if (iw[6:0] == 7'h13 && iw[14:12] == 3'd1) begin
                    ok = (iw[31:25] == 7'h00); v = int'(iw[24:20]);
                end
                if (iw[6:0] == 7'h13 && iw[14:12] == 3'd5) begin
                    ok = (iw[31:25] inside {7'h00, 7'h20}); v = int'(iw[24:20]);
                end
            end
            7'h33: begin
                f = 3'd0; v = 0;
                ok = (iw[31:25] == 7'h00) ||
                     (iw[31:25] == 7'h20 && iw[14:12] inside {3'd0, 3'd5});
            end
            default: ok = 1'b0;
        endcase
        e.illegal = !ok;
        e.fmt     = ok ? f : 3'd7;
        e.imm     = ok ? 32'(v) : 32'd0;
        return e;
    endfunction

    function automatic logic [31:0] gen_word();
        logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 9) != 0) begin
            w[6:0] = ops[$urandom_range(0, 10)];
            if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    default: ;
                endcase
            end
        end
        return w;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("illegal_cnt", illegal_cnt, mcnt);
        if (q.size() > 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_opcode", out_opcode, q[0].opcode);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_rs1", out_rs1, q[0].rs1);
            chk("out_rs2", out_rs2, q[0].rs2);
            chk("out_funct3", out_funct3, q[0].f3);
            chk("out_funct7", out_funct7, q[0].f7);
            chk("out_imm", out_imm, q[0].imm);
            chk("out_fmt", out_fmt, q[0].fmt);
            chk("out_illegal", out_illegal, q[0].illegal);
        end
    endtask

    // One clock: check at negedge, advance model across the posedge.
    task automatic cycle();
        bit acc, pop;
        check_state();
        acc = in_valid && (q.size() < 2);
        pop = out_ready && (q.size() > 0);
        @(posedge clk);
        if (pop) begin
            if (q[0].illegal && mcnt != 16'hFFFF) mcnt++;
            void'(q.pop_front());
        end
        if (flush) q.delete();
        else if (acc) q.push_back(ref_decode(in_iword, in_pc));
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] iw);
        in_valid = 1'b1; in_pc = pc; in_iword = iw;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_iword = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cnt", illegal_cnt, 16'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_fmt", out_fmt, 3'd0);

        // ADDI x1,x0,-1 : one-cycle latency
        out_ready = 1'b1;
        offer(32'h100, 32'hFFF00093); cycle(); in_valid = 1'b0;
        chk("addi_valid", out_valid, 1'b1);
        chk("addi_rd", out_rd, 5'd1);
        chk("addi_fmt", out_fmt, FMT_I);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_illegal", out_illegal, 1'b0);

        offer(32'h104, 32'h0020A423); cycle(); in_valid = 1'b0;
        chk("sw_fmt", out_fmt, FMT_S);
        chk("sw_rs1", out_rs1, 5'd1);
        chk("sw_rs2", out_rs2, 5'd2);
        chk("sw_imm", out_imm, 32'h8);

        offer(32'h108, 32'hFE000EE3); cycle(); in_valid = 1'b0;
        chk("beq_fmt", out_fmt, FMT_B);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);

        offer(32'h10C, 32'h001000EF); cycle(); in_valid = 1'b0;
        chk("jal_fmt", out_fmt, FMT_J);
        chk("jal_imm", out_imm, 32'h800);

        offer(32'h110, 32'h123452B7); cycle(); in_valid = 1'b0;
        chk("lui_fmt", out_fmt, FMT_U);
        chk("lui_imm", out_imm, 32'h12345000);
        cycle();

        // Illegal words and counter
        offer(32'h200, 32'h00000000); cycle(); in_valid = 1'b0;
        chk("ill0_flag", out_illegal, 1'b1);
        chk("ill0_fmt", out_fmt, FMT_NONE);
        chk("ill0_cnt_before", illegal_cnt, 16'd0);
        cycle();
        chk("ill0_cnt_after", illegal_cnt, 16'd1);
        offer(32'h204, 32'h4000F0B3); cycle(); in_valid = 1'b0;
        chk("ill1_flag", out_illegal, 1'b1);
        chk("ill1_imm", out_imm, 32'd0);
        cycle();
        chk("ill1_cnt_after", illegal_cnt, 16'd2);

        // Backpressure: three words offered, two taken, then drained without bubbles
        out_ready = 1'b0;
        offer(32'h300, 32'h00100093); cycle();
        offer(32'h304, 32'h00200093); cycle();
        chk("bp_in_ready_low", in_ready, 1'b0);
        offer(32'h308, 32'h00300093); cycle();
        chk("bp_still_full", in_ready, 1'b0);
        chk("bp_head_pc", out_pc, 32'h300);
        out_ready = 1'b1;
        cycle();
        chk("bp_out1_valid", out_valid, 1'b1);
        chk("bp_out1_pc", out_pc, 32'h304);
        cycle(); in_valid = 1'b0;
        chk("bp_out2_valid", out_valid, 1'b1);
        chk("bp_out2_pc", out_pc, 32'h308);
        cycle();
        chk("bp_drained", out_valid, 1'b0);

        // Flush with two buffered and a word offered
        out_ready = 1'b0;
        offer(32'h400, 32'h00000013); cycle();
        offer(32'h404, 32'h00000013); cycle();
        offer(32'h408, 32'h00000013); flush = 1'b1; cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 1'b0);
        chk("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        cycle(); cycle();
        chk("fl_none_emitted", out_valid, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pc     = $urandom;
            in_iword  = gen_word();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        check_state();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_decode_stage
`default_nettype wire
